// File: rtl/banco_arbitro_escrita_if.sv
// Bus bundle for banco_arbitro_escrita: two writeback requesters, the
// register-bank write/read ports and the status outputs.
// slave modport = arbiter side, master modport = requesters/bank/consumer side.
interface banco_arbitro_escrita_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic [ADDR_W-1:0] rd1_addr;
   logic [ADDR_W-1:0] rd2_addr;
   logic [DATA_W-1:0] bank_dado1;
   logic [DATA_W-1:0] bank_dado2;
   logic [DATA_W-1:0] rd1_data;
   logic [DATA_W-1:0] rd2_data;
   logic              rd1_stall;
   logic              rd2_stall;
   logic [ADDR_W-1:0] bank_WriteAdd;
   logic [DATA_W-1:0] bank_entrada;
   logic              bank_RW;
   logic              grant_ptr;
   logic [7:0]        conflict_cnt;

   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      input  rd1_addr, rd2_addr, bank_dado1, bank_dado2,
      output req0_ready, req1_ready, rd1_data, rd2_data, rd1_stall, rd2_stall,
      output bank_WriteAdd, bank_entrada, bank_RW, grant_ptr, conflict_cnt
   );

   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      output rd1_addr, rd2_addr, bank_dado1, bank_dado2,
      input  req0_ready, req1_ready, rd1_data, rd2_data, rd1_stall, rd2_stall,
      input  bank_WriteAdd, bank_entrada, bank_RW, grant_ptr, conflict_cnt
   );
endinterface

// File: rtl/banco_arbitro_escrita.sv
// Write-port arbiter for the 8x16 register bank: two 1-entry holding slots,
// round-robin grant (write order kept for same-address slots), read-after-write
// hazard flags and a saturating contention counter.
// Optional macro BANCO_ARBITRO_BYPASS_EN forwards the in-flight write to the
// read ports and relaxes the stall to the non-granted slot only.
module banco_arbitro_escrita #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input logic                   clock,
   input logic                   reset,
   banco_arbitro_escrita_if.slave bus
);
   logic [1:0]        r_hold_v;
   logic [ADDR_W-1:0] r_hold_addr [2];
   logic [DATA_W-1:0] r_hold_data [2];
   logic              r_ptr;
   logic              r_older;
   logic [7:0]        r_cnt;

   logic              w_same_addr;
   logic              w_pref;
   logic [1:0]        w_grant;
   logic              w_gidx;
   logic [1:0]        w_ready;
   logic [1:0]        w_load;
   logic [1:0]        w_next_v;
   logic              w_older_d;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [1:0]        w_pend;
   logic [DATA_W-1:0] w_rd1_data;
   logic [DATA_W-1:0] w_rd2_data;

   // Grant decision from registered slot state only
   always_comb begin
      w_same_addr = (r_hold_addr[0] == r_hold_addr[1]);
      // Same address: oldest first keeps write order; otherwise round-robin
      w_pref      = w_same_addr ? r_older : r_ptr;
      w_grant[0]  = r_hold_v[0] & (~r_hold_v[1] | ~w_pref);
      w_grant[1]  = r_hold_v[1] & (~r_hold_v[0] | w_pref);
      w_gidx      = w_grant[1];
   end

   // Bank write port drive; all zero when nothing is granted
   always_comb begin
      w_wr_addr = '0;
      w_wr_data = '0;
      if (|w_grant) begin
         w_wr_addr = r_hold_addr[w_gidx];
         w_wr_data = r_hold_data[w_gidx];
      end
   end

   // Handshake and next-slot occupancy; a slot draining this cycle may refill
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         w_ready[n]  = ~reset & (~r_hold_v[n] | w_grant[n]);
         w_next_v[n] = r_hold_v[n] & ~w_grant[n];
      end
      w_load[0]   = w_ready[0] & bus.req0_valid;
      w_load[1]   = w_ready[1] & bus.req1_valid;
      w_next_v    = w_next_v | w_load;
   end

   // Age tracking: the slot that stays valid while the other loads is older
   always_comb begin
      w_older_d = r_older;
      if (w_load[0] && w_load[1]) begin
         w_older_d = 1'b0;
      end else if (w_load[0] && w_next_v[1]) begin
         w_older_d = 1'b1;
      end else if (w_load[1] && w_next_v[0]) begin
         w_older_d = 1'b0;
      end else if (w_next_v[0] && !w_next_v[1]) begin
         w_older_d = 1'b0;
      end else if (w_next_v[1] && !w_next_v[0]) begin
         w_older_d = 1'b1;
      end
   end

   // Slot, pointer, age and contention-counter state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hold_v    <= '0;
         r_hold_addr <= '{default: '0};
         r_hold_data <= '{default: '0};
         r_ptr       <= 1'b0;
         r_older     <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_hold_v <= w_next_v;
         if (w_load[0]) begin
            r_hold_addr[0] <= bus.req0_addr;
            r_hold_data[0] <= bus.req0_data;
         end
         if (w_load[1]) begin
            r_hold_addr[1] <= bus.req1_addr;
            r_hold_data[1] <= bus.req1_data;
         end
         if (|w_grant) begin
            r_ptr <= ~w_gidx;
         end
         r_older <= w_older_d;
         if ((&r_hold_v) && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // Read-side hazard detection and optional forwarding
   always_comb begin
      w_rd1_data = bus.bank_dado1;
      w_rd2_data = bus.bank_dado2;
`ifdef BANCO_ARBITRO_BYPASS_EN
      // The granted slot lands this cycle, so only the waiting slot can stall
      w_pend = r_hold_v & ~w_grant;
      if ((|w_grant) && (w_wr_addr == bus.rd1_addr)) begin
         w_rd1_data = w_wr_data;
      end
      if ((|w_grant) && (w_wr_addr == bus.rd2_addr)) begin
         w_rd2_data = w_wr_data;
      end
`else
      w_pend = r_hold_v;
`endif
   end

   assign bus.req0_ready    = w_ready[0];
   assign bus.req1_ready    = w_ready[1];
   assign bus.bank_RW       = |w_grant;
   assign bus.bank_WriteAdd = w_wr_addr;
   assign bus.bank_entrada  = w_wr_data;
   assign bus.grant_ptr     = r_ptr;
   assign bus.conflict_cnt  = r_cnt;
   assign bus.rd1_data      = w_rd1_data;
   assign bus.rd2_data      = w_rd2_data;
   assign bus.rd1_stall     = (w_pend[0] & (r_hold_addr[0] == bus.rd1_addr)) |
                              (w_pend[1] & (r_hold_addr[1] == bus.rd1_addr));
   assign bus.rd2_stall     = (w_pend[0] & (r_hold_addr[0] == bus.rd2_addr)) |
                              (w_pend[1] & (r_hold_addr[1] == bus.rd2_addr));
endmodule

// File: tb/tb_banco_arbitro_escrita.sv
// Scoreboard bench for banco_arbitro_escrita: stimulus pushes expected bank
// writes {addr,data}; a negedge monitor pops and compares on every bank_RW.
module tb_banco_arbitro_escrita;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic mon_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] mem [8] = '{default: 16'h0000};
   logic [18:0] exp_q [$];

   banco_arbitro_escrita_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   banco_arbitro_escrita #(.DATA_W(16), .ADDR_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clock = ~clock;

   // Register bank model seen by the arbiter
   always @(posedge clock) begin
      if (bus.bank_RW === 1'b1) mem[bus.bank_WriteAdd] <= bus.bank_entrada;
   end
   assign bus.bank_dado1 = mem[bus.rd1_addr];
   assign bus.bank_dado2 = mem[bus.rd2_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every bank write must match the next expected entry
   always @(negedge clock) begin
      if (mon_en) begin
         if (bus.bank_RW === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual=%h required=none",
                        {bus.bank_WriteAdd, bus.bank_entrada});
            end else begin
               chk("bank_write", {13'd0, bus.bank_WriteAdd, bus.bank_entrada},
                   {13'd0, exp_q.pop_front()});
            end
         end else begin
            chk("idle_bus", {13'd0, bus.bank_WriteAdd, bus.bank_entrada}, 32'd0);
         end
      end
   end

   // One cycle of requester drive; returns readies sampled mid-cycle
   task automatic beat(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                       output logic r0, output logic r1);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      @(negedge clock);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      logic r0, r1;
      for (int i = 0; i < n; i++) beat(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, r0, r1);
   endtask

   // Both requesters stream n beats; writes alternate starting with slot 'first'
   task automatic stream(input int n, input logic first, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [15:0] b0, input logic [15:0] b1);
      int   i0 = 0;
      int   i1 = 0;
      int   cyc = 0;
      logic r0, r1;
      for (int i = 0; i < n; i++) begin
         if (first) begin
            exp_q.push_back({a1, 16'(b1 + i)});
            exp_q.push_back({a0, 16'(b0 + i)});
         end else begin
            exp_q.push_back({a0, 16'(b0 + i)});
            exp_q.push_back({a1, 16'(b1 + i)});
         end
      end
      while ((i0 < n || i1 < n) && cyc < 4 * n + 10) begin
         beat(i0 < n, a0, 16'(b0 + i0), i1 < n, a1, 16'(b1 + i1), r0, r1);
         if (i0 < n && r0) i0++;
         if (i1 < n && r1) i1++;
         cyc++;
      end
      chk("stream_done", {31'd0, (i0 == n && i1 == n)}, 32'd1);
      idle(3);
   endtask

   initial begin
      logic r0, r1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_addr  = '0;
      bus.req1_addr  = '0;
      bus.req0_data  = '0;
      bus.req1_data  = '0;
      bus.rd1_addr   = 3'd0;
      bus.rd2_addr   = 3'd7;
      #1 reset = 1'b1;
      #2;
      mon_en = 1'b1;
      chk("rst_RW", {31'd0, bus.bank_RW}, 32'd0);
      chk("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      chk("rst_ptr", {31'd0, bus.grant_ptr}, 32'd0);
      chk("rst_cnt", {24'd0, bus.conflict_cnt}, 32'd0);
      chk("rst_stall", {30'd0, bus.rd1_stall, bus.rd2_stall}, 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;

      // Single write: visible on the bank port one cycle after acceptance
      exp_q.push_back({3'd3, 16'h1234});
      beat(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0, r0, r1);
      chk("single_ready", {31'd0, r0}, 32'd1);
      bus.req0_valid = 1'b0;
      @(negedge clock);
      chk("single_RW", {31'd0, bus.bank_RW}, 32'd1);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("single_mem", {16'd0, mem[3]}, 32'h1234);
      chk("single_RW_after", {31'd0, bus.bank_RW}, 32'd0);
      @(posedge clock);
      #1;
      chk("ptr_after_slot0", {31'd0, bus.grant_ptr}, 32'd1);

      // Contention from ptr=1: slot1 wins first, then strict alternation
      stream(4, 1'b1, 3'd1, 3'd2, 16'hA000, 16'hB000);
      chk("contend_cnt", {24'd0, bus.conflict_cnt}, 32'd7);
      chk("contend_mem1", {16'd0, mem[1]}, 32'hA003);
      chk("contend_mem2", {16'd0, mem[2]}, 32'hB003);

      // Same address, staggered loads: slot1 then slot0
      exp_q.push_back({3'd5, 16'h0001});
      exp_q.push_back({3'd5, 16'h0002});
      beat(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'h0001, r0, r1);
      beat(1'b1, 3'd5, 16'h0002, 1'b0, 3'd0, 16'd0, r0, r1);
      idle(3);
      chk("same_addr_mem5", {16'd0, mem[5]}, 32'h0002);

      // Same address loaded together with ptr=1: age wins, slot0 written first
      exp_q.push_back({3'd6, 16'h0066});
      exp_q.push_back({3'd5, 16'h0050});
      exp_q.push_back({3'd5, 16'h0051});
      beat(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'd0, r0, r1);
      beat(1'b1, 3'd5, 16'h0050, 1'b1, 3'd5, 16'h0051, r0, r1);
      chk("refill_ready", {30'd0, r0, r1}, 32'd3);
      idle(3);
      chk("older_mem5", {16'd0, mem[5]}, 32'h0051);
      chk("older_cnt", {24'd0, bus.conflict_cnt}, 32'd8);

      // Hazard: slot0 addr4 granted, slot1 addr6 waiting
      bus.rd1_addr = 3'd4;
      bus.rd2_addr = 3'd6;
      exp_q.push_back({3'd4, 16'h4444});
      exp_q.push_back({3'd6, 16'h6666});
      beat(1'b1, 3'd4, 16'h4444, 1'b1, 3'd6, 16'h6666, r0, r1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clock);
`ifdef BANCO_ARBITRO_BYPASS_EN
      chk("haz_rd1_stall", {31'd0, bus.rd1_stall}, 32'd0);
      chk("haz_rd1_data", {16'd0, bus.rd1_data}, 32'h4444);
`else
      chk("haz_rd1_stall", {31'd0, bus.rd1_stall}, 32'd1);
      chk("haz_rd1_data", {16'd0, bus.rd1_data}, 32'h0000);
`endif
      chk("haz_rd2_stall", {31'd0, bus.rd2_stall}, 32'd1);
      chk("haz_rd2_data", {16'd0, bus.rd2_data}, 32'h0066);
      @(posedge clock);
      #1;
      idle(3);
      chk("haz_cnt", {24'd0, bus.conflict_cnt}, 32'd9);
      chk("ptr_before_sat", {31'd0, bus.grant_ptr}, 32'd0);

      // Saturation: 150 beats each keeps both slots full for 299 cycles
      stream(150, 1'b0, 3'd1, 3'd2, 16'hC000, 16'hD000);
      chk("sat_cnt", {24'd0, bus.conflict_cnt}, 32'd255);

      // Reset mid-operation with ptr=1 and both slots full
      exp_q.push_back({3'd7, 16'h0777});
      beat(1'b1, 3'd7, 16'h0777, 1'b0, 3'd0, 16'd0, r0, r1);
      idle(2);
      bus.rd1_addr = 3'd1;
      bus.rd2_addr = 3'd2;
      beat(1'b1, 3'd1, 16'h0E01, 1'b1, 3'd2, 16'h0E02, r0, r1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("midrst_RW", {31'd0, bus.bank_RW}, 32'd0);
      chk("midrst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      idle(3);
      chk("postrst_cnt", {24'd0, bus.conflict_cnt}, 32'd0);
      chk("postrst_ptr", {31'd0, bus.grant_ptr}, 32'd0);
      chk("postrst_stall", {30'd0, bus.rd1_stall, bus.rd2_stall}, 32'd0);
      chk("postrst_mem1", {16'd0, mem[1]}, 32'hC095);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
